period_meter: RTL
=================

Name: period_meter

Overview:
- Measures the number of clk cycles between consecutive rising edges of an asynchronous strobe input.
- It is the receive-side counterpart of the divided-tick generators. It checks or recovers tick rates, e.g. external sync or button-timing strobes, and reports each measured period through a valid/rdy handshake.
- Sits beside the timing generators; results feed debug/LED logic or game-speed calibration.

Parameters:
- WIDTH, 16, width of the period count and result; max reportable value MAX = 2^WIDTH-1.
- SYNC_STAGES, 2, number of synchroniser flops on pulse_in (>=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted), applied to every flop.
- en  input  1  measurement enable.
- pulse_in  input  1  asynchronous strobe whose rising-edge spacing is measured.
- rdy  input  1  consumer ready.
- valid  output  1  result held and available.
- period  output  WIDTH  measured cycles between edges.
- ovf  output  1  qualifies period: no edge arrived within MAX cycles.
- overrun  output  1  a completed result was dropped because the held one was not yet accepted.

Behaviour:
- Reset: state=IDLE, cnt=0, valid=0, period=0, ovf=0, overrun=0, synchroniser and edge flops=0.
- Input path: pulse_in goes through SYNC_STAGES flops, then one history flop.
  - edge = sync_out & ~hist.
  - edge fires SYNC_STAGES+1 cycles after the pulse_in rise. The delay is constant, so periods are unaffected.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: cnt held at 0. en=1 -> ARM.
  - ARM: waiting for the first edge. On edge: cnt<=1 -> MEASURE.
  - MEASURE, no edge: cnt<=cnt+1.
  - MEASURE, edge: publish period=cnt, ovf=0; cnt<=1; stay in MEASURE.
  - MEASURE, cnt==MAX with no edge: publish period=MAX, ovf=1 -> ARM.
  - en=0 in any state -> IDLE next cycle. An in-flight count is discarded; a held result stays valid.
- Period definition: edges detected N cycles apart give period=N. Minimum measurable N=2.
- Latency: valid rises the cycle after the edge-detect cycle that completes the period.
- Output handshake:
  - A transfer occurs on any cycle with valid&rdy. valid drops the next cycle unless a new result loads in that same cycle.
  - A publish loads period/ovf and sets valid when valid=0 or a transfer occurs in the same cycle.
  - A publish when valid=1 & rdy=0: the new result is dropped, the held period/ovf are unchanged, overrun<=1.
  - overrun is sticky. It clears on the cycle after the next transfer, unless another drop occurs in that same cycle.
  - period/ovf are stable while valid=1 & rdy=0.
- Simultaneous events:
  - edge in the same cycle as cnt==MAX: the edge wins; publish MAX with ovf=0.
  - en falling in the same cycle as an edge: no publish.
- Asynchronous reset asserted mid-measurement: all state returns to reset values immediately. The first edge after release only arms.
- Counter is WIDTH bits and never wraps; it saturates at MAX through the timeout path.

Optional Feature:
- Macro: PERIOD_METER_AVG_EN.
- Defined:
  - Each non-ovf period is added to a WIDTH+2-bit accumulator. After 4 periods, publish floor(sum/4) with ovf=0, then clear the accumulator and window count.
  - A timeout publishes MAX with ovf=1 immediately, clears the window, and goes to ARM.
  - en=0 clears the window.
  - Handshake and overrun rules are unchanged; they apply to averaged publishes.
- Undefined: every period is published individually, as described in Behaviour. No accumulator logic is present.

Test Plan:
- WIDTH=8, en=1, rdy=1, pulse_in rising every 10 cycles for 5 edges -> 4 results, each period=10, ovf=0, overrun=0; no result for the first edge.
- Edges 3 cycles apart, then 257 cycles apart, WIDTH=8 -> period=3 ovf=0, then period=255 ovf=1. The next edge re-arms with no result; the following edge 20 cycles later -> period=20.
- rdy=0, edges every 12 cycles for 3 edges -> first result period=12 held valid, overrun=1 after the second publish. Raise rdy for one cycle -> transfer of 12; valid=0 next cycle; overrun clears the cycle after the transfer.
- valid=1 with rdy=1 in the same cycle as a new publish of 7 -> transfer occurs, valid stays 1 with period=7, overrun stays 0.
- Assert reset (0) midway through a 50-cycle period -> valid=0, period=0, state IDLE immediately. After release, edges at 0,30,60 -> single result period=30, then 30.
- With PERIOD_METER_AVG_EN, edges spaced 10,12,14,16 -> one result period=13. Periods 10,11,11,11 -> period=10 (floor of 43/4).

Source files
------------

// File: rtl/period_meter_if.sv
// ---------------------------------------------------------------------------
// period_meter_if
//   Result handshake bundle of the period meter.
//
//   valid   : a measured result is held and available (meter -> consumer)
//   rdy     : consumer ready; valid & rdy on a cycle is a transfer
//   period  : measured clk cycles between strobe edges (WIDTH bits)
//   ovf     : qualifies period; no edge arrived within the maximum count
//   overrun : sticky; a completed result was dropped while one was held
//
//   master : the meter (drives valid/period/ovf/overrun, samples rdy)
//   slave  : the consumer (samples results, drives rdy)
// ---------------------------------------------------------------------------
interface period_meter_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic             rdy;
  logic [WIDTH-1:0] period;
  logic             ovf;
  logic             overrun;

  modport master (
    output valid,
    output period,
    output ovf,
    output overrun,
    input  rdy
  );

  modport slave (
    input  valid,
    input  period,
    input  ovf,
    input  overrun,
    output rdy
  );
endinterface

// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------
// period_meter
//   Counts clk cycles between consecutive rising edges of an asynchronous
//   strobe and reports each period through a valid/rdy handshake.
//
//   Parameters
//     WIDTH       : width of the period counter and result (MAX = 2^WIDTH-1)
//     SYNC_STAGES : synchroniser depth on pulse_in (must be >= 2)
//
//   Ports
//     clk      : system clock
//     reset    : asynchronous active-low reset, clears every flop
//     en       : measurement enable; dropping it abandons the running count
//     pulse_in : asynchronous strobe whose rising-edge spacing is measured
//     res      : result handshake (period_meter_if.master)
//
//   Build option
//     PERIOD_METER_AVG_EN : when defined, four consecutive non-overflow
//     periods are summed and their floor average is published instead of
//     each individual period. Timeouts are still published immediately.
// ---------------------------------------------------------------------------
module period_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           pulse_in,
  period_meter_if.master res
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

`ifdef PERIOD_METER_AVG_EN
  // Floor of the 4-period sum: a plain right shift by two.
  function automatic logic [WIDTH-1:0] floor_div4(input logic [WIDTH+1:0] sum);
    return sum[WIDTH+1:2];
  endfunction
`endif

  // ---- stage p0: synchroniser chain and edge-history flop ----
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p0;
  logic                   edge_det;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      hist_p0 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pulse_in};
      hist_p0 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_p0[SYNC_STAGES-1] & ~hist_p0;

  // ---- stage p1: measurement FSM and period counter ----
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pub;
  logic [WIDTH-1:0] pub_period;
  logic             pub_ovf;

`ifdef PERIOD_METER_AVG_EN
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [1:0]       win_q, win_d;
  logic [WIDTH+1:0] acc_sum;

  assign acc_sum = acc_q + {2'b00, cnt_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      win_q <= 2'd0;
    end else begin
      acc_q <= acc_d;
      win_q <= win_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pub        = 1'b0;
    pub_period = cnt_q;
    pub_ovf    = 1'b0;
`ifdef PERIOD_METER_AVG_EN
    acc_d      = acc_q;
    win_d      = win_q;
`endif

    if (!en) begin
      // Disabling discards the in-flight count; a held result is untouched.
      state_d = IDLE;
      cnt_d   = '0;
`ifdef PERIOD_METER_AVG_EN
      acc_d   = '0;
      win_d   = 2'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end

        ARM: begin
          // The first edge only starts the count; it has no predecessor.
          if (edge_det) begin
            cnt_d   = ONE;
            state_d = MEASURE;
          end
        end

        MEASURE: begin
          if (edge_det) begin
            // An edge coinciding with cnt==MAX is a valid period of MAX.
            cnt_d = ONE;
`ifdef PERIOD_METER_AVG_EN
            if (win_q == 2'd3) begin
              pub        = 1'b1;
              pub_period = floor_div4(acc_sum);
              acc_d      = '0;
              win_d      = 2'd0;
            end else begin
              acc_d = acc_sum;
              win_d = win_q + 2'd1;
            end
`else
            pub        = 1'b1;
            pub_period = cnt_q;
`endif
          end else if (cnt_q == MAX) begin
            // Timeout: report saturation and wait for a fresh first edge.
            pub        = 1'b1;
            pub_period = MAX;
            pub_ovf    = 1'b1;
            cnt_d      = '0;
            state_d    = ARM;
`ifdef PERIOD_METER_AVG_EN
            acc_d      = '0;
            win_d      = 2'd0;
`endif
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---- stage p2: result holding register and handshake ----
  logic             vld_p2;
  logic [WIDTH-1:0] period_p2;
  logic             ovf_p2;
  logic             overrun_p2;
  logic             xfer;
  logic             drop;

  assign xfer = vld_p2 & res.rdy;
  // A new result can only be accepted if the slot is empty or emptying now.
  assign drop = pub & vld_p2 & ~res.rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2     <= 1'b0;
      period_p2  <= '0;
      ovf_p2     <= 1'b0;
      overrun_p2 <= 1'b0;
    end else begin
      if (pub && (!vld_p2 || xfer)) begin
        vld_p2    <= 1'b1;
        period_p2 <= pub_period;
        ovf_p2    <= pub_ovf;
      end else if (xfer) begin
        vld_p2 <= 1'b0;
      end

      if (drop) begin
        overrun_p2 <= 1'b1;
      end else if (xfer) begin
        overrun_p2 <= 1'b0;
      end
    end
  end

  assign res.valid   = vld_p2;
  assign res.period  = period_p2;
  assign res.ovf     = ovf_p2;
  assign res.overrun = overrun_p2;

endmodule
